// File: rtl/sample_dump_pkg.sv
// Shared types and constants for the sample_dump block.
//   state_t     : controller states
//   CMD_S_*     : command bytes that start a capture
//   ASCII_*     : line terminator / separator characters
//   nib2ascii() : 4-bit value to uppercase ASCII hex digit
package sample_dump_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        FETCH    = 3'd2,
        GAP      = 3'd3,
        EMIT     = 3'd4,
        WAIT_ACK = 3'd5
    } state_t;

    localparam logic [7:0] CMD_S_LC = 8'h73;
    localparam logic [7:0] CMD_S_UC = 8'h53;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sample_dump_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, one-cycle read latency.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : read/write address
//   i_wdata : write data
//   o_rdata : data at the address presented on the previous clock
module sample_dump_ram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_dump.sv
// Captures DEPTH ADC samples on an 's'/'S' command byte and streams each as an
// ASCII hex line (digits, LF, CR) over a byte valid/ready port.
// Optional feature macro: SAMPLE_DUMP_INDEX_EN prefixes each line with the
// sample index in hex followed by a space.
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_sample_in, i_sample_valid   : ADC sample stream
//   i_rx_data, i_rx_valid, o_rx_ready : command byte input (always ready)
//   o_tx_data, o_tx_valid, i_tx_ready : ASCII byte output
//   o_busy                        : high outside IDLE
//   o_done                        : one-cycle pulse after the final CR is accepted
module sample_dump
    import sample_dump_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned GAP_CYCLES = 5000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_sample_in,
    input  logic              i_sample_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned NIB = (DATA_W + 3) / 4;
`ifdef SAMPLE_DUMP_INDEX_EN
    localparam int unsigned IDX_NIB = (AW + 3) / 4;
    localparam int unsigned PRE     = IDX_NIB + 1;
`else
    localparam int unsigned IDX_NIB = 0;
    localparam int unsigned PRE     = 0;
`endif
    localparam int unsigned SW       = (IDX_NIB + NIB) * 4;
    localparam int unsigned LINE_LEN = PRE + NIB + 2;
    localparam int unsigned CW       = $clog2(LINE_LEN);
    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] C_LF     = CW'(LINE_LEN - 2);
    localparam logic [CW-1:0] C_CR     = CW'(LINE_LEN - 1);
`ifdef SAMPLE_DUMP_INDEX_EN
    localparam logic [CW-1:0] C_SP     = CW'(PRE - 1);
`endif
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no pacing the GAP state is skipped entirely.
    localparam state_t AFTER_CHAR = (GAP_CYCLES == 0) ? EMIT : GAP;

    state_t          r_state, w_state_d;
    logic [AW-1:0]   r_wr_idx, w_wr_idx_d;
    logic [AW-1:0]   r_rd_idx, w_rd_idx_d;
    logic [CW-1:0]   r_char_idx, w_char_idx_d;
    logic [GW-1:0]   r_gap_cnt, w_gap_cnt_d;
    logic [SW-1:0]   r_shift, w_shift_d;
    logic            r_fetch_ph, w_fetch_ph_d;
    logic [7:0]      r_tx_data, w_tx_data_d;
    logic            r_tx_valid, w_tx_valid_d;
    logic            r_done, w_done_d;

    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic [SW-1:0]   w_line_word;
    logic [7:0]      w_char;
    logic            w_is_digit;

    sample_dump_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (i_sample_in),
        .o_rdata (w_rdata)
    );

    // Digits of the whole line (optional index, then zero-padded sample) live in
    // one shift register; the top nibble is always the next digit to send.
    always_comb begin
        w_line_word = '0;
        w_line_word[DATA_W-1:0] = w_rdata;
`ifdef SAMPLE_DUMP_INDEX_EN
        w_line_word[NIB*4 +: AW] = r_rd_idx;
`endif
    end

    always_comb begin
        w_char     = nib2ascii(r_shift[SW-1 -: 4]);
        w_is_digit = 1'b0;
        if (r_char_idx == C_CR) begin
            w_char = ASCII_CR;
        end else if (r_char_idx == C_LF) begin
            w_char = ASCII_LF;
`ifdef SAMPLE_DUMP_INDEX_EN
        end else if (r_char_idx == C_SP) begin
            w_char = ASCII_SP;
`endif
        end else begin
            w_is_digit = 1'b1;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_wr_idx_d   = r_wr_idx;
        w_rd_idx_d   = r_rd_idx;
        w_char_idx_d = r_char_idx;
        w_gap_cnt_d  = r_gap_cnt;
        w_shift_d    = r_shift;
        w_fetch_ph_d = r_fetch_ph;
        w_tx_data_d  = r_tx_data;
        w_tx_valid_d = r_tx_valid;
        w_done_d     = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_rd_idx;

        unique case (r_state)
            IDLE: begin
                if (i_rx_valid && (i_rx_data == CMD_S_LC || i_rx_data == CMD_S_UC)) begin
                    w_state_d  = CAPTURE;
                    w_wr_idx_d = '0;
                end
            end
            CAPTURE: begin
                w_addr = r_wr_idx;
                if (i_sample_valid) begin
                    w_we = 1'b1;
                    if (r_wr_idx == IDX_LAST) begin
                        w_state_d    = FETCH;
                        w_rd_idx_d   = '0;
                        w_fetch_ph_d = 1'b0;
                    end else begin
                        w_wr_idx_d = r_wr_idx + AW'(1);
                    end
                end
            end
            FETCH: begin
                // Phase 0 issues the read, phase 1 latches the returned word.
                if (!r_fetch_ph) begin
                    w_fetch_ph_d = 1'b1;
                end else begin
                    w_fetch_ph_d = 1'b0;
                    w_shift_d    = w_line_word;
                    w_char_idx_d = '0;
                    w_gap_cnt_d  = '0;
                    w_state_d    = AFTER_CHAR;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_d = '0;
                    w_state_d   = EMIT;
                end else begin
                    w_gap_cnt_d = r_gap_cnt + GW'(1);
                end
            end
            EMIT: begin
                w_tx_valid_d = 1'b1;
                w_tx_data_d  = w_char;
                w_state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_tx_ready) begin
                    w_tx_valid_d = 1'b0;
                    if (w_is_digit) begin
                        w_shift_d = {r_shift[SW-5:0], 4'h0};
                    end
                    if (r_char_idx == C_CR) begin
                        if (r_rd_idx == IDX_LAST) begin
                            w_state_d = IDLE;
                            w_done_d  = 1'b1;
                        end else begin
                            w_rd_idx_d = r_rd_idx + AW'(1);
                            w_state_d  = FETCH;
                        end
                    end else begin
                        w_char_idx_d = r_char_idx + CW'(1);
                        w_state_d    = AFTER_CHAR;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_char_idx <= '0;
            r_gap_cnt  <= '0;
            r_shift    <= '0;
            r_fetch_ph <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wr_idx   <= w_wr_idx_d;
            r_rd_idx   <= w_rd_idx_d;
            r_char_idx <= w_char_idx_d;
            r_gap_cnt  <= w_gap_cnt_d;
            r_shift    <= w_shift_d;
            r_fetch_ph <= w_fetch_ph_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_valid <= w_tx_valid_d;
            r_done     <= w_done_d;
        end
    end

    assign o_rx_ready = 1'b1;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;

endmodule

// File: tb/tb_sample_dump.sv
// Scoreboard bench for sample_dump (DEPTH=4, GAP_CYCLES=3). Expected line bytes are
// queued when samples are issued; a monitor pops and compares on every accepted byte.
// Honours SAMPLE_DUMP_INDEX_EN for the expected line format.
module tb_sample_dump;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned GAP_CYCLES = 3;
    localparam int unsigned NIB        = 6;
    localparam int unsigned AW         = 2;
`ifdef SAMPLE_DUMP_INDEX_EN
    localparam int unsigned IDX_NIB = (AW + 3) / 4;
    localparam int unsigned PRE     = IDX_NIB + 1;
`else
    localparam int unsigned IDX_NIB = 0;
    localparam int unsigned PRE     = 0;
`endif
    localparam int unsigned LINE_LEN = PRE + NIB + 2;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    sample_dump #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_in    (sample_in),
        .i_sample_valid (sample_valid),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (rx_ready),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned accepted    = 0;
    int unsigned done_cnt    = 0;
    int unsigned ready_mode  = 0;   // 0 always ready, 1 random, 2 held low
    logic [7:0]  exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hex_char(input int unsigned d);
        return (d < 10) ? 8'(48 + d) : 8'(65 + d - 10);
    endfunction

    // Reference line: optional index digits + space, sample hex MSB first, LF, CR.
    task automatic push_line(input int unsigned idx, input logic [DATA_W-1:0] val);
        int unsigned v;
        v = 32'(val);
`ifdef SAMPLE_DUMP_INDEX_EN
        for (int k = 0; k < int'(IDX_NIB); k++)
            exp_q.push_back(hex_char((idx >> (4 * (int'(IDX_NIB) - 1 - k))) & 15));
        exp_q.push_back(8'h20);
`else
        if (idx > DEPTH) $display("bad index %0d", idx);
`endif
        for (int k = 0; k < int'(NIB); k++)
            exp_q.push_back(hex_char((v >> (4 * (int'(NIB) - 1 - k))) & 15));
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // tx_ready driver, updated just after each rising edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, hold stability, inter-byte spacing.
    initial begin
        logic       prev_hold = 1'b0;
        logic       prev_v    = 1'b0;
        logic       have_rise = 1'b0;
        logic [7:0] hold_data = '0;
        logic [7:0] e;
        int unsigned last_rise = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
                prev_v    = 1'b0;
                have_rise = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_hold) begin
                    check("tx_hold_valid", 32'(tx_valid), 32'd1);
                    check("tx_hold_data", 32'(tx_data), 32'(hold_data));
                end
                if (tx_valid && !prev_v) begin
                    if (have_rise)
                        check("tx_gap", 32'((cyc - last_rise) >= GAP_CYCLES), 32'd1);
                    last_rise = cyc;
                    have_rise = 1'b1;
                end
                if (tx_valid && tx_ready) begin
                    accepted++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(e));
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                hold_data = tx_data;
                prev_v    = tx_valid;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Command byte (with a junk sample on the same cycle) then DEPTH paced samples.
    task automatic run_capture(input logic [7:0] cmd, input logic [DATA_W-1:0] smp [DEPTH]);
        for (int i = 0; i < int'(DEPTH); i++) push_line(i, smp[i]);
        rx_data      = cmd;
        rx_valid     = 1'b1;
        sample_in    = DATA_W'($urandom);
        sample_valid = 1'b1;
        tick();
        rx_valid     = 1'b0;
        sample_valid = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            repeat ($urandom_range(0, 3)) tick();
            sample_in    = smp[i];
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned n = 0;
        while (done_cnt < target && n < 5000) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_accepted(input int unsigned target);
        int unsigned n = 0;
        while (accepted < target && n < 5000) begin
            tick();
            n++;
        end
        check("bytes_reached", 32'(accepted >= target), 32'd1);
    endtask

    task automatic rand_samples(output logic [DATA_W-1:0] smp [DEPTH]);
        for (int i = 0; i < int'(DEPTH); i++) smp[i] = DATA_W'($urandom);
    endtask

    initial begin
        logic [DATA_W-1:0] fx [DEPTH];
        logic [DATA_W-1:0] rs [DEPTH];
        int unsigned base_done;
        int unsigned n;
        fx[0] = 24'h12ABCF;
        fx[1] = 24'h000001;
        fx[2] = 24'hFFFFFF;
        fx[3] = 24'h0F0F0F;

        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Non-command bytes are drained and ignored.
        send_byte(8'h78);
        send_byte(8'h71);
        repeat (10) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_rx_ready", 32'(rx_ready), 32'd1);
        end

        // Known samples, free-flowing tx.
        ready_mode = 0;
        run_capture(8'h53, fx);
        wait_done(1);
        tick();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_done_count", 32'(done_cnt), 32'd1);

        // Backpressure: hold tx_ready low 50 clocks on a pending byte.
        rand_samples(rs);
        run_capture(8'h73, rs);
        n = 0;
        while (!tx_valid && n < 1000) begin
            tick();
            n++;
        end
        check("t3_tx_valid_seen", 32'(tx_valid), 32'd1);
        ready_mode = 2;
        repeat (50) tick();
        ready_mode = 1;
        wait_done(2);
        ready_mode = 0;
        tick();
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Commands and stray samples during a dump are ignored.
        base_done = done_cnt;
        rand_samples(rs);
        run_capture(8'h53, rs);
        wait_accepted(accepted + 5);
        send_byte(8'h73);
        sample_in    = DATA_W'($urandom);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        send_byte(8'h53);
        wait_done(base_done + 1);
        repeat (60) tick();
        check("t5_one_done", 32'(done_cnt - base_done), 32'd1);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);

        // Reset after two lines, then a fresh dump.
        rand_samples(rs);
        run_capture(8'h73, rs);
        wait_accepted(accepted + 2 * LINE_LEN);
        rst_n = 1'b0;
        #1;
        check("t4_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        base_done = done_cnt;
        rand_samples(rs);
        run_capture(8'h73, rs);
        wait_done(base_done + 1);
        tick();
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t4_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
